// File: rtl/decoder_pkg.sv
// Shared types for the one-cold decoder with optional auto-scan.
// Scan support is built only with DECODER_SCAN_EN defined.
package decoder_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      MANUAL = 2'd1,
      SCAN   = 2'd2
   } state_e;

   localparam logic [2:0] EN_PATTERN = 3'b100;

endpackage

// File: rtl/decoder_scan_if.sv
// Pin bundle of decoder_scan: gate, select, mode, direction and led bus.
// Scan pins (mode, dir) are ignored unless DECODER_SCAN_EN is defined.
interface decoder_scan_if #(
   parameter int SEL_W = 3
);

   localparam int OUT_W = 2 ** SEL_W;

   logic [2:0]       enable;
   logic [SEL_W-1:0] switch;
   logic             mode;
   logic             dir;
   logic [OUT_W-1:0] led;

   modport master (
      output enable,
      output switch,
      output mode,
      output dir,
      input  led
   );

   modport slave (
      input  enable,
      input  switch,
      input  mode,
      input  dir,
      output led
   );

endinterface

// File: rtl/decoder_scan_tick_gen.sv
// Scan-step divider: counts run cycles and pulses tick at DIV-1.
// Instantiated by decoder_scan only when DECODER_SCAN_EN is defined.
module tick_gen #(
   parameter int DIV = 50_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic run,
   output logic tick
);

   localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   assign tick = run && (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (run) begin
         cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/decoder_scan.sv
// 3-to-8 style one-cold decoder with gate pins and optional auto-scan.
// Define DECODER_SCAN_EN to build the SCAN state, divider and index.
module decoder_scan
   import decoder_pkg::*;
#(
   parameter int SEL_W = 3,
   parameter int DIV   = 50_000_000
) (
   input  logic           clk,
   input  logic           rst,
   decoder_scan_if.slave  bus
);

   localparam int OUT_W = 2 ** SEL_W;

   function automatic logic [OUT_W-1:0] one_cold(
      input logic [SEL_W-1:0] i
   );
      one_cold = ~(OUT_W'(1) << i);
   endfunction

   state_e           state_q;
   state_e           state_d;
   logic [OUT_W-1:0] led_q;
   logic [OUT_W-1:0] led_d;
   logic             enabled;

   assign enabled = (bus.enable == EN_PATTERN);

`ifdef DECODER_SCAN_EN
   logic [SEL_W-1:0] idx_q;
   logic [SEL_W-1:0] idx_d;
   logic             res_q;
   logic             res_d;
   logic             load;
   logic             run;
   logic             tick;

   always_comb begin
      state_d = IDLE;
      if (enabled) begin
         state_d = bus.mode ? SCAN : MANUAL;
      end
   end

   // res_q marks a scan suspended by the gate; resume skips the reload
   always_comb begin
      load  = (state_d == SCAN) && (state_q != SCAN) && !res_q;
      run   = (state_d == SCAN) && (state_q == SCAN);
      idx_d = idx_q;
      res_d = res_q;
      if (load) begin
         idx_d = bus.switch;
      end else if (run && tick) begin
         idx_d = bus.dir ? idx_q - SEL_W'(1)
                         : idx_q + SEL_W'(1);
      end
      if (state_d == MANUAL) begin
         res_d = 1'b0;
      end else if (state_q == SCAN && state_d == IDLE) begin
         res_d = 1'b1;
      end
   end

   tick_gen #(
      .DIV (DIV)
   ) u_tick (
      .clk  (clk),
      .rst  (rst),
      .clr  (load),
      .run  (run),
      .tick (tick)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         idx_q <= '0;
         res_q <= 1'b0;
      end else begin
         idx_q <= idx_d;
         res_q <= res_d;
      end
   end
`else
   logic unused_scan;

   assign unused_scan = ^{bus.mode, bus.dir};

   always_comb begin
      state_d = enabled ? MANUAL : IDLE;
   end
`endif

   always_comb begin
      led_d = '1;
      unique case (state_d)
         IDLE:    led_d = '1;
         MANUAL:  led_d = one_cold(bus.switch);
`ifdef DECODER_SCAN_EN
         SCAN:    led_d = one_cold(idx_d);
`endif
         default: led_d = '1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         led_q   <= '1;
      end else begin
         state_q <= state_d;
         led_q   <= led_d;
      end
   end

   assign bus.led = led_q;

endmodule

// File: tb/tb_decoder_scan.sv
// Scoreboard bench for decoder_scan (SEL_W=3, DIV=4).
// Honours DECODER_SCAN_EN the same way the design does.
module tb_decoder_scan;

   localparam int SEL_W = 3;
   localparam int DIV   = 4;
   localparam int OUT_W = 8;
`ifdef DECODER_SCAN_EN
   localparam bit SCAN_ON = 1'b1;
`else
   localparam bit SCAN_ON = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   decoder_scan_if #(.SEL_W(SEL_W)) bus ();

   decoder_scan #(
      .SEL_W (SEL_W),
      .DIV   (DIV)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [7:0] led;
      string      tag;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   // reference: 0 = gated off, 1 = manual, 2 = scanning
   int m_st  = 0;
   int m_idx = 0;
   int m_cnt = 0;
   bit m_res = 1'b0;

   function automatic logic [7:0] cold(input int i);
      logic [7:0] one;
      one = 8'h01;
      return 8'hFF ^ (one << i);
   endfunction

   task model_step(
      input  bit         r,
      input  logic [2:0] en,
      input  int         sw,
      input  bit         md,
      input  bit         dr,
      output logic [7:0] led
   );
      int nxt;
      if (r) begin
         m_st  = 0;
         m_idx = 0;
         m_cnt = 0;
         m_res = 1'b0;
         led   = 8'hFF;
         return;
      end
      nxt = (en != 3'b100) ? 0 : ((SCAN_ON && md) ? 2 : 1);
      if (nxt == 2) begin
         if (m_st != 2 && !m_res) begin
            m_idx = sw;
            m_cnt = 0;
         end else if (m_st == 2) begin
            m_cnt = m_cnt + 1;
            if (m_cnt == DIV) begin
               m_cnt = 0;
               m_idx = (m_idx + (dr ? OUT_W - 1 : 1)) % OUT_W;
            end
         end
      end
      if (nxt == 1) m_res = 1'b0;
      else if (m_st == 2 && nxt == 0) m_res = 1'b1;
      m_st = nxt;
      if (nxt == 0)      led = 8'hFF;
      else if (nxt == 1) led = cold(sw);
      else               led = cold(m_idx);
   endtask

   task drive(
      input bit         r,
      input logic [2:0] en,
      input int         sw,
      input bit         md,
      input bit         dr,
      input string      tag,
      input bit         fix,
      input logic [7:0] want
   );
      exp_t       e;
      logic [7:0] mled;
      @(negedge clk);
      rst        = r;
      bus.enable = en;
      bus.switch = sw[2:0];
      bus.mode   = md;
      bus.dir    = dr;
      model_step(r, en, sw, md, dr, mled);
      e.led = fix ? want : mled;
      e.tag = tag;
      q.push_back(e);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            checks++;
            if (bus.led !== e.led) begin
               errors++;
               $display("FAIL %s: led=%h expected %h",
                        e.tag, bus.led, e.led);
            end
         end
      end
   end

   initial begin : stim
      logic [2:0] bad [4];
      logic [2:0] en;
      bit         r, md, dr;
      int         sw;
      bad = '{3'b000, 3'b101, 3'b110, 3'b111};
      rst        = 1'b1;
      bus.enable = 3'b100;
      bus.switch = 3'b101;
      bus.mode   = 1'b0;
      bus.dir    = 1'b0;

      drive(1, 3'b100, 5, 0, 0, "rst_hold", 1, 8'hFF);
      drive(1, 3'b100, 5, 0, 0, "rst_hold", 1, 8'hFF);
      drive(0, 3'b100, 5, 0, 0, "rst_release", 1, 8'hDF);
      for (int i = 0; i < 4; i++)
         drive(0, bad[i], $urandom_range(7), 0, 0,
               "gate_off", 1, 8'hFF);
      drive(0, 3'b100, 3, 0, 0, "gate_on", 1, 8'hF7);

`ifdef DECODER_SCAN_EN
      drive(0, 3'b100, 6, 0, 0, "man6", 1, 8'hBF);
      for (int i = 0; i < 4; i++)
         drive(0, 3'b100, 6, 1, 0, "up_bf", 1, 8'hBF);
      for (int i = 0; i < 4; i++)
         drive(0, 3'b100, $urandom_range(7), 1, 0,
               "up_7f", 1, 8'h7F);
      drive(0, 3'b100, 6, 1, 0, "wrap_up", 1, 8'hFE);

      drive(0, 3'b100, 0, 0, 1, "man0", 1, 8'hFE);
      for (int i = 0; i < 4; i++)
         drive(0, 3'b100, 0, 1, 1, "dn_fe", 1, 8'hFE);
      for (int i = 0; i < 4; i++)
         drive(0, 3'b100, 0, 1, 1, "dn_7f", 1, 8'h7F);
      for (int i = 0; i < 4; i++)
         drive(0, 3'b100, 0, 1, 1, "dn_bf", 1, 8'hBF);

      drive(0, 3'b100, 2, 0, 0, "man2", 1, 8'hFB);
      for (int i = 0; i < 3; i++)
         drive(0, 3'b100, 2, 1, 0, "pre_hold", 1, 8'hFB);
      for (int i = 0; i < 10; i++)
         drive(0, 3'b000, 2, 1, 0, "hold_off", 1, 8'hFF);
      drive(0, 3'b100, 5, 1, 0, "resume_fb", 1, 8'hFB);
      drive(0, 3'b100, 5, 1, 0, "resume_fb", 1, 8'hFB);
      drive(0, 3'b100, 5, 1, 0, "resume_step", 1, 8'hF7);

      drive(1, 3'b100, 4, 1, 0, "rst_mid", 1, 8'hFF);
      drive(0, 3'b100, 4, 1, 0, "rst_scan_load", 1, 8'hEF);
`else
      for (int i = 0; i < 100; i++)
         drive(0, 3'b100, 2, 1, 1, "noscan", 1, 8'hFB);
`endif

      r  = 0;
      md = 0;
      dr = 0;
      sw = 0;
      for (int i = 0; i < 400; i++) begin
         r  = ($urandom_range(39) == 0);
         en = ($urandom_range(9) < 8) ? 3'b100
                                      : 3'($urandom_range(7));
         if ($urandom_range(19) == 0) md = ~md;
         if ($urandom_range(14) == 0) dr = ~dr;
         if ($urandom_range(3) == 0)  sw = $urandom_range(7);
         drive(r, en, sw, md, dr, "random", 0, 8'h00);
      end

      repeat (2) @(posedge clk);
      #2;
      if (q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain: %0d left, expected 0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule

// File: doc/decoder_scan.md
DECODER_SCAN -- requirements
Module: decoder_scan

Interface
REQ-001 SHALL have parameter SEL_W, default 3, meaning select width; OUT_W = 2**SEL_W outputs.
REQ-002 SHALL have parameter DIV, default 50_000_000, meaning clk cycles per scan step (legal range DIV >= 1).
REQ-003 SHALL have port clk  input  1  meaning system clock, all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  meaning synchronous active-high reset, sampled on the clk rising edge.
REQ-005 SHALL have port enable  input  3  meaning gate pins {G1, G2B, G2A}; the block is enabled only when enable == 3'b100.
REQ-006 SHALL have port switch  input  SEL_W  meaning manual select index, and the scan start index.
REQ-007 SHALL have port mode  input  1  meaning 0 = manual, 1 = auto-scan.
REQ-008 SHALL have port dir  input  1  meaning scan direction: 0 = up, 1 = down.
REQ-009 SHALL have port led  output  OUT_W  meaning registered one-cold output; the selected bit is 0, all others are 1.

Function
REQ-010 SHALL implement a state machine with states IDLE, MANUAL and SCAN, updated each clk edge.
REQ-011 SHALL go to IDLE whenever enable != 3'b100, from any state.
REQ-012 SHALL, when enabled, go to MANUAL if mode = 0 and to SCAN if mode = 1.
REQ-013 SHALL drive led = all ones in IDLE, registered.
REQ-014 SHALL, in MANUAL, drive led = ~(1 << switch) with exactly 1 clk latency from the switch change.
REQ-015 SHALL, in SCAN, drive led = ~(1 << idx), where idx is an SEL_W-bit scan index register.
REQ-016 SHALL, on entry to SCAN from MANUAL or from reset, load idx = switch and clear the divider.
REQ-017 SHALL, in SCAN, increment the divider each cycle; at count DIV-1 it wraps to 0 and steps idx by one step (up: +1, down: -1).
REQ-018 SHALL wrap idx modulo OUT_W: OUT_W-1 -> 0 going up, 0 -> OUT_W-1 going down.
REQ-019 SHALL, with DIV = 1, step idx every enabled SCAN cycle.
REQ-020 SHALL, on SCAN -> IDLE, hold idx and the divider value; on IDLE -> SCAN, resume from the held values without reloading (no reload from switch).
REQ-021 SHALL, on IDLE -> MANUAL, follow switch on the next cycle.
REQ-022 SHALL apply a dir change at the next step only, with no extra step and no divider reset.
REQ-023 SHALL NOT reload idx on a switch change during SCAN.

Reset
REQ-024 SHALL, when rst = 1 at a clk edge, set state = IDLE, led = all ones, idx = 0 and divider = 0.
REQ-025 SHALL give rst priority over enable, mode and every other input, including a reset asserted mid-scan.
REQ-026 SHALL, on the first edge after rst is released, evaluate the state transitions normally.

Configuration
REQ-027 SHALL compile the SCAN state, the divider and idx in only when the macro DECODER_SCAN_EN is defined.
REQ-028 SHALL, when DECODER_SCAN_EN is undefined, ignore mode and dir, treat mode as 0 (MANUAL only), and synthesize no divider or idx logic.

Structure
REQ-029 SHALL place the state enum (IDLE/MANUAL/SCAN) and the constant EN_PATTERN = 3'b100 in the shared package decoder_pkg.
REQ-030 SHALL implement the divider as sub-module tick_gen (parameter DIV; ports clk, rst, clr, run, tick).
REQ-031 SHALL raise tick from tick_gen for one cycle at each terminal count.
REQ-032 SHALL keep the one-cold decode in decoder_scan, as a plain function of the index.

Verification (SEL_W = 3, DIV = 4, macro defined unless noted)
REQ-033 SHALL cover: rst = 1 with enable = 100, switch = 101, mode = 0 -> led = 8'hFF; first edge after release -> led = 8'hDF.
REQ-034 SHALL cover: enable = 000, 101, 110 or 111 with any switch value -> led = 8'hFF; enable = 100, switch = 011 -> led = 8'hF7 one cycle later.
REQ-035 SHALL cover: mode 0 -> 1, switch = 110, dir = 0 -> led = 8'hBF for 4 cycles, then 8'h7F for 4 cycles, then 8'hFE (wrap).
REQ-036 SHALL cover: scan from switch = 000 with dir = 1 -> led sequence FE, 7F, BF, each value held 4 cycles.
REQ-037 SHALL cover: enable dropped to 000 for 10 cycles at divider = 2 while led = 8'hFB -> led = 8'hFF for those cycles; after re-enable, 8'hFB holds 2 more cycles, then 8'hF7.
REQ-038 SHALL cover: with DECODER_SCAN_EN undefined, mode = 1, dir = 1, switch = 010 -> led = 8'hFB steady and no stepping for 100 cycles.
